fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction-fetch front end of the mp4 core. Drives the instruction port of the dual-port magic memory (pc, imem_read, imem_resp, instr) and buffers returned instructions with their PCs in a small FIFO. Decode consumes the buffered {pc, instr} pairs over a valid/ready handshake. Control-flow redirects from execute flush the unit and restart fetch at a new PC.

## Interface
- RESET_PC, 32'h0000_0060: first fetch address after reset
- DEPTH, 2: FIFO entries (power of two, ≥2)
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-low reset
- imem_addr  out  32  fetch address, driven to the memory pc port
- imem_read  out  1  fetch request, held until imem_resp
- imem_rdata  in  32  returned instruction, valid when imem_resp=1
- imem_resp  in  1  one-cycle response pulse
- if_valid  out  1  FIFO head valid
- if_ready  in  1  decode accepts head this cycle
- if_pc  out  32  PC of head entry
- if_instr  out  32  instruction of head entry
- redirect  in  1  flush and refetch, one-cycle pulse
- redirect_pc  in  32  new fetch PC, sampled when redirect=1

## Operation
- States: IDLE (no request), REQ (request outstanding), DISCARD (outstanding request whose data will be dropped).
- Credit rule: issue a request only when count + outstanding < DEPTH; the FIFO therefore never overflows.
- IDLE -> REQ when credit is available: imem_read=1, imem_addr=fetch_pc.
- REQ: imem_read and imem_addr held stable until imem_resp. On imem_resp, push {fetch_pc, imem_rdata}, fetch_pc += 4 (mod 2^32, wraps 0xFFFF_FFFC -> 0). Stay in REQ with the new address if credit remains after the push/pop; otherwise go to IDLE.
- Pop: if_valid && if_ready removes the head. Push and pop in the same cycle are allowed at any occupancy.
- Redirect (highest priority):
  - FIFO is flushed (count=0, any same-cycle pop is superseded); fetch_pc <= redirect_pc.
  - REQ without imem_resp that cycle -> DISCARD; old imem_addr held with imem_read=1 until imem_resp; the response is dropped; then REQ at redirect_pc.
  - REQ with imem_resp the same cycle: the response is dropped; next cycle REQ at redirect_pc.
  - IDLE: next cycle REQ at redirect_pc.
  - Redirect while in DISCARD: fetch_pc is updated and the unit stays in DISCARD.
- redirect_pc[1:0] is ignored (forced 0).
- if_pc and if_instr are don't-care when if_valid=0.

## Timing
- Reset (rst=0 at an edge): state=IDLE, fetch_pc=RESET_PC, FIFO empty. Outputs: imem_read=0, imem_addr=RESET_PC, if_valid=0. A reset during an outstanding request abandons it with no discard; the memory model tolerates this.
- First imem_read=1 in the first cycle after rst samples 1.
- Memory response latency ≥1 cycle; with 1-cycle latency and if_ready=1 every cycle, the unit sustains one instruction per cycle. imem_read stays high across back-to-back requests while imem_addr advances.
- FIFO write to if_valid: 1 cycle (registered FIFO, no bypass).
- Redirect to first request at the new PC: next cycle, unless in DISCARD.
- All outputs come straight from registers; no combinational path from if_ready, redirect, or imem_resp to any output.

## Structure
- fetch_pkg: fetch_state_t enum {IDLE, REQ, DISCARD}, fetch_entry_t struct {pc[31:0], instr[31:0]}, and the RESET_PC default.
- Sub-module fetch_fifo: parameterised DEPTH of fetch_entry_t, with push, pop, flush, count, and head outputs; flush has priority over push.
- fetch_unit holds the FSM, fetch_pc, credit logic, and redirect handling.

## Test plan
- Reset release, 1-cycle memory, if_ready=1: requests at 0x60, 0x64, 0x68, with one instr per cycle at if_* from the 3rd cycle; if_pc sequence is 0x60, 0x64, 0x68.
- if_ready=0 for 10 cycles: exactly DEPTH=2 entries are buffered, imem_read=0 after the second response, and no overflow; release gives in-order output.
- 3-cycle memory latency, redirect to 0x200 at latency cycle 1: imem_addr holds the old address until the resp, the response is dropped, the next request is at 0x200, and the first if_pc is 0x200.
- redirect to 0x400 in the same cycle as imem_resp and a pop: the FIFO is empty next cycle, the dropped data never appears, and the next request is at 0x400.
- fetch_pc=0xFFFF_FFFC: the next request is at 0x0000_0000.
- rst=0 asserted while imem_read=1: imem_read=0 and if_valid=0 the next cycle, and the restart is at 0x60.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
// Contents: fetch FSM state enum, {pc, instr} FIFO entry, reset PC default,
// and a helper that word-aligns a PC.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,  // no request outstanding
    REQ     = 2'd1,  // request outstanding, response will be kept
    DISCARD = 2'd2   // request outstanding, response will be dropped
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  localparam logic [31:0] FETCH_RESET_PC = 32'h0000_0060;
  localparam logic [31:0] FETCH_STEP     = 32'd4;

  // Instructions are word aligned; the low two bits of any external PC are dropped.
  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return pc & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Registered FIFO of {pc, instr} entries between fetch and decode.
// Latency: push to valid_o/head_o is 1 cycle (no bypass).
// Backpressure: pop only when non-empty; push ignored when full and not popping; flush beats push and pop.
// Ports: clk_i, rst_ni (sync active-low), push_i/entry_i, pop_i, flush_i,
//        count_o (occupancy), valid_o (head valid), head_o (head entry).
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               push_i,
  input  fetch_entry_t       entry_i,
  input  logic               pop_i,
  input  logic               flush_i,
  output logic [CNT_W-1:0]   count_o,
  output logic               valid_o,
  output fetch_entry_t       head_o
);

  fetch_entry_t     mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W-1:0] wr_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop_i && (count_q != '0);
  // A simultaneous pop frees the slot, so push is accepted even when full.
  assign do_push = push_i && ((count_q != CNT_W'(DEPTH)) || do_pop);

  always_ff @(posedge clk_i) begin
    if (!rst_ni || flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // Storage needs no reset: occupancy alone decides what is visible.
  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= entry_i;
  end

  assign count_o = count_q;
  assign valid_o = (count_q != '0);
  assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: drives imem requests and buffers {pc, instr} for decode.
// Latency: imem_resp to if_valid 1 cycle; redirect to new request 1 cycle (longer if a request must be discarded).
// Backpressure: requests issue only while FIFO occupancy plus outstanding stays below DEPTH; decode pops on if_valid && if_ready.
// Ports: clk, rst (sync active-low); imem_addr/imem_read/imem_rdata/imem_resp to memory;
//        if_valid/if_ready/if_pc/if_instr to decode; redirect/redirect_pc from execute.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = FETCH_RESET_PC,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  output logic        imem_read,
  input  logic [31:0] imem_rdata,
  input  logic        imem_resp,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  input  logic        redirect,
  input  logic [31:0] redirect_pc
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  fetch_state_t     state_q;
  logic [31:0]      fetch_pc_q;
  logic [31:0]      imem_addr_q;
  logic             imem_read_q;

  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_d;
  logic             push;
  logic             pop;
  logic             credit;
  logic             fifo_valid;
  logic [31:0]      pc_inc;
  logic [31:0]      redir_pc;
  fetch_entry_t     push_entry;
  fetch_entry_t     head;

  assign redir_pc   = align_pc(redirect_pc);
  assign pc_inc     = fetch_pc_q + FETCH_STEP;  // wraps naturally at 2^32
  assign push       = (state_q == REQ) && imem_resp && !redirect;
  assign pop        = fifo_valid && if_ready;
  assign push_entry = '{pc: fetch_pc_q, instr: imem_rdata};

  // Occupancy after this edge. A new request can return at most one entry,
  // so one free slot after the push/pop is enough to issue it.
  always_comb begin
    count_d = count;
    if (redirect) begin
      count_d = '0;
    end else begin
      count_d = count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  assign credit = (count_d < CNT_W'(DEPTH));

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (rst),
    .push_i  (push),
    .entry_i (push_entry),
    .pop_i   (pop),
    .flush_i (redirect),
    .count_o (count),
    .valid_o (fifo_valid),
    .head_o  (head)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      fetch_pc_q  <= RESET_PC;
      imem_addr_q <= RESET_PC;
      imem_read_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (redirect) begin
            fetch_pc_q  <= redir_pc;
            imem_addr_q <= redir_pc;
            imem_read_q <= 1'b1;
            state_q     <= REQ;
          end else if (credit) begin
            imem_addr_q <= fetch_pc_q;
            imem_read_q <= 1'b1;
            state_q     <= REQ;
          end
        end

        REQ: begin
          if (redirect) begin
            fetch_pc_q <= redir_pc;
            if (imem_resp) begin
              // Response lands with the redirect: drop it, restart at once.
              imem_addr_q <= redir_pc;
              imem_read_q <= 1'b1;
              state_q     <= REQ;
            end else begin
              // Memory still owns the old address; hold it until it answers.
              state_q <= DISCARD;
            end
          end else if (imem_resp) begin
            fetch_pc_q  <= pc_inc;
            imem_addr_q <= pc_inc;
            if (credit) begin
              imem_read_q <= 1'b1;
              state_q     <= REQ;
            end else begin
              imem_read_q <= 1'b0;
              state_q     <= IDLE;
            end
          end
        end

        DISCARD: begin
          if (redirect) fetch_pc_q <= redir_pc;
          if (imem_resp) begin
            // The FIFO was flushed on entry and nothing is pushed here, so
            // there is always room for the restart request. A redirect in the
            // same cycle as this response retargets the restart directly.
            imem_addr_q <= redirect ? redir_pc : fetch_pc_q;
            imem_read_q <= 1'b1;
            state_q     <= REQ;
          end
        end

        default: begin
          state_q     <= IDLE;
          imem_read_q <= 1'b0;
        end
      endcase
    end
  end

  assign imem_addr = imem_addr_q;
  assign imem_read = imem_read_q;
  assign if_valid  = fifo_valid;
  assign if_pc     = head.pc;
  assign if_instr  = head.instr;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: memory model with programmable latency,
// scoreboard queue of expected FIFO contents, table of redirect vectors,
// and hand sequences for reset, backpressure, discard and same-cycle redirect.
module tb_fetch_unit;
  import fetch_pkg::*;

  logic        clk;
  logic        rst;
  logic [31:0] imem_addr;
  logic        imem_read;
  logic [31:0] imem_rdata;
  logic        imem_resp;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        redirect;
  logic [31:0] redirect_pc;

  int checks   = 0;
  int failures = 0;

  int          lat = 1;
  logic        in_req;
  int          wcnt;
  logic [31:0] req_addr;
  logic [31:0] req_log[$];
  logic [31:0] pop_log[$];
  logic [31:0] sb_q[$];
  logic        discard;
  logic        mon_en = 1'b0;

  typedef struct {
    logic [31:0] rpc;
    logic        ready;
    logic [31:0] exp0;
    logic [31:0] exp1;
  } vec_t;
  vec_t vecs[5];

  fetch_unit dut (
    .clk         (clk),
    .rst         (rst),
    .imem_addr   (imem_addr),
    .imem_read   (imem_read),
    .imem_rdata  (imem_rdata),
    .imem_resp   (imem_resp),
    .if_valid    (if_valid),
    .if_ready    (if_ready),
    .if_pc       (if_pc),
    .if_instr    (if_instr),
    .redirect    (redirect),
    .redirect_pc (redirect_pc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return a ^ 32'hDEAD_BEEF;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // Memory: a request starts when imem_read is seen high with none pending;
  // the response pulses in the lat-th cycle the request has been presented.
  initial begin
    imem_resp  = 1'b0;
    imem_rdata = '0;
    in_req     = 1'b0;
    wcnt       = 0;
    req_addr   = '0;
    forever begin
      @(posedge clk);
      #1;
      if (imem_read === 1'b1) begin
        if (!in_req) begin
          in_req   = 1'b1;
          wcnt     = 1;
          req_addr = imem_addr;
          req_log.push_back(imem_addr);
        end else begin
          wcnt++;
          chk("addr_hold", imem_addr, req_addr);
        end
      end else begin
        in_req = 1'b0;
      end
      if (in_req && wcnt >= lat) begin
        imem_resp  = 1'b1;
        imem_rdata = instr_of(req_addr);
        in_req     = 1'b0;
      end else begin
        imem_resp  = 1'b0;
        imem_rdata = '0;
      end
    end
  end

  // Scoreboard: sb_q holds what the FIFO must contain. Sampled at negedge,
  // these are exactly the values the DUT acts on at the next rising edge.
  initial begin
    discard = 1'b0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        chk("if_valid", if_valid, sb_q.size() != 0);
        chk("sb_depth", sb_q.size() <= 2, 1'b1);
        if (if_valid && if_ready && sb_q.size() != 0) begin
          chk("if_pc", if_pc, sb_q[0]);
          chk("if_instr", if_instr, instr_of(sb_q[0]));
          if (rst && !redirect) pop_log.push_back(if_pc);
        end
        if (!rst) begin
          sb_q.delete();
          discard = 1'b0;
        end else if (redirect) begin
          sb_q.delete();
          discard = imem_read && !imem_resp;
        end else begin
          if (if_valid && if_ready && sb_q.size() != 0) void'(sb_q.pop_front());
          if (imem_resp && imem_read) begin
            if (discard) discard = 1'b0;
            else sb_q.push_back(imem_addr);
          end
        end
      end
    end
  end

  initial begin
    int          t;
    int          n0;
    int          mr;
    int          mp;
    int          nbad;
    logic [31:0] old_addr;
    logic [31:0] dropped;
    logic        seen;

    vecs[0] = '{rpc: 32'h0000_1000, ready: 1'b1, exp0: 32'h0000_1000, exp1: 32'h0000_1004};
    vecs[1] = '{rpc: 32'h0000_0403, ready: 1'b0, exp0: 32'h0000_0400, exp1: 32'h0000_0404};
    vecs[2] = '{rpc: 32'h0000_07FE, ready: 1'b1, exp0: 32'h0000_07FC, exp1: 32'h0000_0800};
    vecs[3] = '{rpc: 32'hFFFF_FFFC, ready: 1'b1, exp0: 32'hFFFF_FFFC, exp1: 32'h0000_0000};
    vecs[4] = '{rpc: 32'hFFFF_FFFF, ready: 1'b0, exp0: 32'hFFFF_FFFC, exp1: 32'h0000_0000};

    rst         = 1'b0;
    if_ready    = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;

    // Reset state.
    cyc(3);
    chk("rst_read", imem_read, 1'b0);
    chk("rst_valid", if_valid, 1'b0);
    chk("rst_addr", imem_addr, 32'h0000_0060);
    mon_en = 1'b1;

    // Release, 1-cycle memory, decode always ready.
    rst      = 1'b1;
    if_ready = 1'b1;
    cyc(1);
    chk("first_read", imem_read, 1'b1);
    chk("first_addr", imem_addr, 32'h0000_0060);
    cyc(1);
    chk("first_valid", if_valid, 1'b1);
    n0 = pop_log.size();
    cyc(8);
    chk("throughput", pop_log.size() - n0, 8);
    for (int k = 0; k < 3; k++) begin
      chk("req_seq", req_log[k], 32'h0000_0060 + 32'(4 * k));
      chk("pop_seq", pop_log[k], 32'h0000_0060 + 32'(4 * k));
    end

    // Decode stalls: exactly DEPTH entries buffered, fetch stops.
    if_ready = 1'b0;
    cyc(10);
    chk("stall_read", imem_read, 1'b0);
    chk("stall_valid", if_valid, 1'b1);
    chk("stall_fill", sb_q.size(), 2);
    if_ready = 1'b1;
    cyc(8);
    nbad = 0;
    for (int k = 1; k < pop_log.size(); k++)
      if (pop_log[k] != pop_log[k-1] + 32'd4) nbad++;
    chk("pc_order", nbad, 0);

    // 3-cycle memory, redirect in latency cycle 1 forces a discard.
    lat = 3;
    t = 0;
    while (!(imem_read && wcnt == 1 && !imem_resp) && t < 20) begin
      cyc(1);
      t++;
    end
    chk("disc_wait", t < 20, 1'b1);
    old_addr    = imem_addr;
    mr          = req_log.size();
    mp          = pop_log.size();
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0200;
    cyc(1);
    redirect = 1'b0;
    chk("disc_hold1", imem_addr, old_addr);
    chk("disc_read1", imem_read, 1'b1);
    cyc(1);
    chk("disc_hold2", imem_addr, old_addr);
    cyc(1);
    chk("disc_new_addr", imem_addr, 32'h0000_0200);
    chk("disc_new_read", imem_read, 1'b1);
    t = 0;
    while (pop_log.size() <= mp && t < 20) begin
      cyc(1);
      t++;
    end
    chk("disc_pop_wait", t < 20, 1'b1);
    if (pop_log.size() > mp) chk("disc_first_pc", pop_log[mp], 32'h0000_0200);
    if (req_log.size() > mr) chk("disc_req", req_log[mr], 32'h0000_0200);

    // Redirect in the same cycle as a response and a pop.
    lat = 1;
    cyc(3);
    t = 0;
    while (!(imem_resp && if_valid) && t < 20) begin
      cyc(1);
      t++;
    end
    chk("same_wait", t < 20, 1'b1);
    dropped     = imem_addr;
    mp          = pop_log.size();
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0400;
    cyc(1);
    redirect = 1'b0;
    chk("same_valid", if_valid, 1'b0);
    chk("same_addr", imem_addr, 32'h0000_0400);
    chk("same_read", imem_read, 1'b1);
    cyc(6);
    seen = 1'b0;
    for (int k = mp; k < pop_log.size(); k++)
      if (pop_log[k] == dropped) seen = 1'b1;
    chk("same_dropped", seen, 1'b0);
    if (pop_log.size() > mp) chk("same_first_pc", pop_log[mp], 32'h0000_0400);

    // Table of redirect targets: alignment and address wrap.
    for (int i = 0; i < 5; i++) begin
      if_ready = vecs[i].ready;
      cyc(3);
      mr          = req_log.size();
      mp          = pop_log.size();
      redirect    = 1'b1;
      redirect_pc = vecs[i].rpc;
      cyc(1);
      redirect = 1'b0;
      chk("vec_addr0", imem_addr, vecs[i].exp0);
      cyc(3);
      chk("vec_req_cnt", req_log.size() >= mr + 2, 1'b1);
      if (req_log.size() >= mr + 2) begin
        chk("vec_req0", req_log[mr], vecs[i].exp0);
        chk("vec_req1", req_log[mr+1], vecs[i].exp1);
      end
      if (vecs[i].ready) begin
        if (pop_log.size() > mp) chk("vec_pop0", pop_log[mp], vecs[i].exp0);
        else chk("vec_pop_cnt", pop_log.size(), mp + 1);
      end else begin
        chk("vec_head_valid", if_valid, 1'b1);
        chk("vec_head_pc", if_pc, vecs[i].exp0);
      end
    end
    if_ready = 1'b1;

    // Reset while a request is outstanding.
    lat = 3;
    cyc(1);
    t = 0;
    while (!(imem_read && !imem_resp) && t < 20) begin
      cyc(1);
      t++;
    end
    chk("rst2_wait", t < 20, 1'b1);
    rst = 1'b0;
    cyc(1);
    chk("rst2_read", imem_read, 1'b0);
    chk("rst2_valid", if_valid, 1'b0);
    mr  = req_log.size();
    rst = 1'b1;
    cyc(1);
    chk("rst2_restart_read", imem_read, 1'b1);
    chk("rst2_restart_addr", imem_addr, 32'h0000_0060);
    cyc(8);
    if (req_log.size() > mr) chk("rst2_req", req_log[mr], 32'h0000_0060);
    else chk("rst2_req_cnt", req_log.size(), mr + 1);
    if (pop_log.size() > 0) chk("rst2_pop", pop_log[pop_log.size()-1] >= 32'h0000_0060, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
